// File: rtl/mem_bus_ctrl_pkg.sv
// Shared types and decode constants for the CPU-to-peripheral bus controller.
// Regions, FSM states and address-field positions live here.
package mem_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    REG_RAM   = 2'd0,
    REG_GPIO  = 2'd1,
    REG_UART  = 2'd2,
    REG_TIMER = 2'd3
  } region_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2,
    S_ERR    = 2'd3
  } state_e;

  localparam int UPPER_LSB  = 18;
  localparam int REGION_MSB = 17;
  localparam int REGION_LSB = 16;

endpackage

// File: rtl/mem_bus_ctrl_decode.sv
// Combinational address decoder: mapped flag plus region index.
// Addresses with any bit set at or above UPPER_LSB are unmapped.
import mem_bus_ctrl_pkg::*;

module bus_addr_decode #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] addr,
  output logic             mapped,
  output region_e          region
);

  assign mapped = (addr[WIDTH-1:UPPER_LSB] == '0);
  assign region = region_e'(addr[REGION_MSB:REGION_LSB]);

endmodule

// File: rtl/mem_bus_ctrl.sv
// Single-outstanding bus controller: decodes a CPU request, drives one
// peripheral until it is ready or a wait limit expires, then responds.
import mem_bus_ctrl_pkg::*;

module mem_bus_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_we,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             req_ready,
  output logic             resp_valid,
  output logic             resp_err,
  output logic [3:0]       per_sel,
  output logic             per_we,
  output logic [15:0]      per_addr,
  output logic [WIDTH-1:0] per_wdata,
  input  logic [3:0]       per_ready,
  output logic [1:0]       rdsel
);

  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_e           state_q, state_d;
  region_e          region_q, region_d;
  logic             we_q, we_d;
  logic [15:0]      addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             err_q, err_d;
  logic [1:0]       rdsel_q, rdsel_d;
  logic [7:0]       cnt_q, cnt_d;

  logic    dec_mapped;
  region_e dec_region;

  bus_addr_decode #(
    .WIDTH(WIDTH)
  ) u_dec (
    .addr  (req_addr),
    .mapped(dec_mapped),
    .region(dec_region)
  );

  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    rdsel_d  = rdsel_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          cnt_d = '0;
          if (dec_mapped) begin
            region_d = dec_region;
            we_d     = req_we;
            addr_d   = req_addr[15:0];
            wdata_d  = req_wdata;
            rdsel_d  = dec_region;
            state_d  = S_ACCESS;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_ACCESS: begin
        if (cnt_q != TO) cnt_d = cnt_q + 8'd1;
        // Ready beats a simultaneous timeout.
        if (per_ready[region_q]) begin
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q >= TO - 8'd1) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      region_q <= REG_RAM;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rdsel_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      rdsel_q  <= rdsel_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_RESP) || (state_q == S_ERR);
    resp_err   = (state_q == S_ERR) || ((state_q == S_RESP) && err_q);
    per_sel    = '0;
    per_we     = 1'b0;
    if (state_q == S_ACCESS) begin
      per_sel = 4'b0001 << region_q;
      per_we  = we_q;
    end
  end

  assign per_addr  = addr_q;
  assign per_wdata = wdata_q;
  assign rdsel     = rdsel_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl with hand-computed expectations.
// Built with TIMEOUT = 4 so the wait-limit path is short.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_err;
  logic [3:0]  per_sel;
  logic        per_we;
  logic [15:0] per_addr;
  logic [31:0] per_wdata;
  logic [3:0]  per_ready;
  logic [1:0]  rdsel;

  int vecs = 0;
  int errs = 0;

  mem_bus_ctrl #(
    .WIDTH  (32),
    .TIMEOUT(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_err  (resp_err),
    .per_sel   (per_sel),
    .per_we    (per_we),
    .per_addr  (per_addr),
    .per_wdata (per_wdata),
    .per_ready (per_ready),
    .rdsel     (rdsel)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    per_ready = '0;
    step();
    step();
    rst = 1'b0;

    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rvalid", 32'(resp_valid), 32'd0);
    chk("rst_rerr", 32'(resp_err), 32'd0);
    chk("rst_sel", 32'(per_sel), 32'd0);
    chk("rst_we", 32'(per_we), 32'd0);
    chk("rst_addr", 32'(per_addr), 32'd0);
    chk("rst_wdata", per_wdata, 32'd0);
    chk("rst_rdsel", 32'(rdsel), 32'd0);

    // Read UART, ready immediately
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h0002_0004;
    per_ready = 4'b0100;
    step();
    req_valid = 1'b0;
    chk("rd_sel", 32'(per_sel), 32'h4);
    chk("rd_addr", 32'(per_addr), 32'h4);
    chk("rd_rdsel", 32'(rdsel), 32'd2);
    chk("rd_we", 32'(per_we), 32'd0);
    chk("rd_ready_lo", 32'(req_ready), 32'd0);
    chk("rd_novalid", 32'(resp_valid), 32'd0);
    step();
    chk("rd_rvalid", 32'(resp_valid), 32'd1);
    chk("rd_rerr", 32'(resp_err), 32'd0);
    chk("rd_resp_sel", 32'(per_sel), 32'd0);
    chk("rd_resp_rdsel", 32'(rdsel), 32'd2);
    per_ready = '0;
    step();
    chk("rd_idle_rv", 32'(resp_valid), 32'd0);
    chk("rd_idle_rdy", 32'(req_ready), 32'd1);

    // Write GPIO, ready on third ACCESS cycle
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h0001_0010;
    req_wdata = 32'hDEAD_BEEF;
    step();
    req_valid = 1'b0;
    req_wdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) per_ready = 4'b0010;
      chk("wr_sel", 32'(per_sel), 32'h2);
      chk("wr_we", 32'(per_we), 32'd1);
      chk("wr_wdata", per_wdata, 32'hDEAD_BEEF);
      chk("wr_rv_lo", 32'(resp_valid), 32'd0);
      if (i < 2) step();
    end
    chk("wr_addr", 32'(per_addr), 32'h10);
    step();
    per_ready = '0;
    chk("wr_rvalid", 32'(resp_valid), 32'd1);
    chk("wr_rerr", 32'(resp_err), 32'd0);
    chk("wr_resp_we", 32'(per_we), 32'd0);
    step();
    chk("wr_rdsel", 32'(rdsel), 32'd1);

    // Unmapped access
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h0004_0000;
    step();
    req_valid = 1'b0;
    chk("um_sel", 32'(per_sel), 32'd0);
    chk("um_rvalid", 32'(resp_valid), 32'd1);
    chk("um_rerr", 32'(resp_err), 32'd1);
    chk("um_rdsel", 32'(rdsel), 32'd1);
    step();
    chk("um_idle_rv", 32'(resp_valid), 32'd0);
    chk("um_idle_rdy", 32'(req_ready), 32'd1);

    // Timeout on TIMER; stray RAM ready ignored
    req_valid = 1'b1;
    req_addr  = 32'h0003_0008;
    step();
    req_valid = 1'b0;
    per_ready = 4'b0001;
    chk("to_sel", 32'(per_sel), 32'h8);
    step();
    per_ready = 4'b0000;
    chk("to_c2_rv", 32'(resp_valid), 32'd0);
    chk("to_c2_sel", 32'(per_sel), 32'h8);
    step();
    chk("to_c3_rv", 32'(resp_valid), 32'd0);
    step();
    chk("to_c4_rv", 32'(resp_valid), 32'd0);
    chk("to_c4_sel", 32'(per_sel), 32'h8);
    step();
    chk("to_rvalid", 32'(resp_valid), 32'd1);
    chk("to_rerr", 32'(resp_err), 32'd1);
    chk("to_rdsel", 32'(rdsel), 32'd3);
    step();
    chk("to_idle", 32'(req_ready), 32'd1);

    // Reset during second ACCESS cycle
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h0000_0100;
    req_wdata = 32'h1234_5678;
    step();
    req_valid = 1'b0;
    step();
    chk("rs_sel_pre", 32'(per_sel), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rs_ready", 32'(req_ready), 32'd1);
    chk("rs_rvalid", 32'(resp_valid), 32'd0);
    chk("rs_sel", 32'(per_sel), 32'd0);
    chk("rs_we", 32'(per_we), 32'd0);
    chk("rs_addr", 32'(per_addr), 32'd0);
    chk("rs_wdata", per_wdata, 32'd0);
    chk("rs_rdsel", 32'(rdsel), 32'd0);
    step();
    chk("rs_no_resp", 32'(resp_valid), 32'd0);

    // Back-to-back with req_valid held
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h0002_0004;
    per_ready = 4'b0110;
    step();
    req_addr  = 32'h0001_0008;
    chk("bb_acc_rdy", 32'(req_ready), 32'd0);
    chk("bb_acc_sel", 32'(per_sel), 32'h4);
    step();
    chk("bb_resp_rdy", 32'(req_ready), 32'd0);
    chk("bb_resp_rv", 32'(resp_valid), 32'd1);
    chk("bb_resp_addr", 32'(per_addr), 32'h4);
    step();
    chk("bb_idle_rdy", 32'(req_ready), 32'd1);
    chk("bb_idle_rv", 32'(resp_valid), 32'd0);
    step();
    req_valid = 1'b0;
    chk("bb2_sel", 32'(per_sel), 32'h2);
    chk("bb2_addr", 32'(per_addr), 32'h8);
    chk("bb2_rdsel", 32'(rdsel), 32'd1);
    step();
    chk("bb2_rv", 32'(resp_valid), 32'd1);
    chk("bb2_rerr", 32'(resp_err), 32'd0);
    per_ready = '0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, data and address width.
REQ-002 Parameter TIMEOUT, default 255, maximum number of ACCESS cycles to wait for peripheral ready; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  CPU access request.
REQ-006 req_we  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  WIDTH  byte address.
REQ-008 req_wdata  input  WIDTH  write data.
REQ-009 req_ready  output  1  request accepted this cycle.
REQ-010 resp_valid  output  1  one-cycle completion pulse.
REQ-011 resp_err  output  1  qualifies resp_valid: unmapped address or timeout.
REQ-012 per_sel  output  4  one-hot peripheral select.
REQ-013 per_we  output  1  write strobe to the selected peripheral.
REQ-014 per_addr  output  16  offset within the region (latched req_addr[15:0]).
REQ-015 per_wdata  output  WIDTH  latched write data.
REQ-016 per_ready  input  4  per-peripheral completion, indexed by region.
REQ-017 rdsel  output  2  read-mux select for the downstream 4:1 read multiplexer.

Function
REQ-018 Region decode: mapped iff req_addr[WIDTH-1:18] == 0; region = req_addr[17:16] (0 RAM, 1 GPIO, 2 UART, 3 TIMER); any other address is unmapped.
REQ-019 FSM states are IDLE, ACCESS, RESP, and ERR; the reset state is IDLE.
REQ-020 req_ready = 1 only in IDLE; a request is accepted when req_valid && req_ready.
REQ-021 IDLE, accept with a mapped address: latch region, we, addr[15:0], and wdata, then go to ACCESS; rdsel <= region in the same edge.
REQ-022 IDLE, accept with an unmapped address: go to ERR; no per_sel is asserted; rdsel is unchanged.
REQ-023 ACCESS: per_sel = one-hot(region) and per_we = latched we, held constant; the wait counter increments each cycle.
REQ-024 ACCESS, per_ready[region] == 1: go to RESP with err = 0; ready bits of unselected regions are ignored.
REQ-025 ACCESS, the wait counter reaches TIMEOUT with no ready: go to RESP with err = 1.
REQ-026 If ready and timeout occur in the same cycle, ready wins (err = 0).
REQ-027 RESP: resp_valid = 1 and resp_err = latched err for exactly one cycle, then return to IDLE; per_sel = 0 and per_we = 0.
REQ-028 ERR: resp_valid = 1 and resp_err = 1 for one cycle, then return to IDLE.
REQ-029 Latency for a mapped access with immediate ready: accept at cycle N, ACCESS at N+1, resp_valid at N+2; this gives a minimum of 3 cycles between consecutive accepts.
REQ-030 rdsel holds its value from accept through RESP and until the next mapped accept, so the read mux output is valid while resp_valid is high.
REQ-031 The wait counter is 8 bits, clears on accept, and never wraps; it saturates at TIMEOUT.
REQ-032 req_* inputs are ignored outside IDLE.

Reset
REQ-033 On rst = 1 at a clock edge, the state returns to IDLE, including mid-ACCESS; any in-flight access is dropped without a response.
REQ-034 Reset values: req_ready = 1 after reset, resp_valid = 0, resp_err = 0, per_sel = 0, per_we = 0, per_addr = 0, per_wdata = 0, rdsel = 0, wait counter = 0.

Structure
REQ-035 A shared package holds the region enum (RAM, GPIO, UART, TIMER), the FSM state enum, and the region-decode constants (upper-address bit 18, region bits 17:16).
REQ-036 One sub-module, bus_addr_decode, is combinational: address in, mapped flag and region out.
REQ-037 The existing 4:1 read multiplexer is instantiated externally by the integrator, not inside this block.

Verification
REQ-038 Read 0x0002_0004 with per_ready[2] = 1 immediately: per_sel = 0100, per_addr = 0x0004, rdsel = 2, resp_valid at the accept cycle + 2, resp_err = 0.
REQ-039 Write 0x0001_0010 with data 0xDEADBEEF, per_ready[1] after 3 cycles: per_we = 1 and per_wdata = 0xDEADBEEF held for 3 ACCESS cycles, then resp_valid with err = 0.
REQ-040 Access to 0x0004_0000 (unmapped): no per_sel, resp_valid and resp_err = 1 at the accept cycle + 1, rdsel unchanged.
REQ-041 TIMEOUT = 4, target region 3, per_ready held at 0: resp_err = 1 after 4 ACCESS cycles; per_ready[0] pulsed during ACCESS has no effect.
REQ-042 rst asserted in the second ACCESS cycle: the next cycle is IDLE, all outputs are at reset values, and no resp_valid is produced.
REQ-043 Back-to-back req_valid held high: req_ready is low during ACCESS and RESP, and the second request is accepted only after IDLE is re-entered.
